tt_um_jleugeri_event_arbiter: RTL and testbench
===============================================

TT_UM_JLEUGERI_EVENT_ARBITER -- requirements
Module: tt_um_jleugeri_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 4, number of event processor cores served.
REQ-002 SHALL have parameter ID_BITS, default 2, width of source index (= clog2(NUM_SOURCES)).
REQ-003 SHALL have port clock  input  1  single clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port token_start  input  NUM_SOURCES  per-source single-cycle start pulse.
REQ-006 SHALL have port token_end  input  NUM_SOURCES  per-source single-cycle end pulse.
REQ-007 SHALL have port event_valid  output  1  output event present.
REQ-008 SHALL have port event_ready  input  1  consumer accepts event this cycle.
REQ-009 SHALL have port event_source  output  ID_BITS  index of emitting source.
REQ-010 SHALL have port event_kind  output  1  0 = start, 1 = end.
REQ-011 SHALL have port overflow  output  NUM_SOURCES  sticky per-source lost-event flag.
REQ-012 SHALL have port clear_overflow  input  1  pulse clearing all overflow bits.

Function
REQ-013 SHALL keep per source: pend_start, pend_end, older bit (1 = end captured before start).
REQ-014 SHALL set pend_start/pend_end on the posedge where the matching pulse is sampled high.
REQ-015 SHALL set older when an event of one kind is captured while the other kind is pending; cleared when either is granted.
REQ-016 SHALL, when a source has both kinds pending, present the older one first (start if older=0).
REQ-017 SHALL grant among sources with any pending event using round-robin; pointer moves to (granted+1) mod NUM_SOURCES after each grant.
REQ-018 SHALL hold a registered output slot; slot loads a granted event when empty or when event_valid && event_ready in the same cycle.
REQ-019 SHALL hold event_source/event_kind stable while event_valid && !event_ready.
REQ-020 SHALL give latency 2 edges: pulse sampled at edge N -> event_valid high after edge N+1 if no contention.
REQ-021 SHALL sustain one event per cycle with event_ready held high.
REQ-022 SHALL, when a pulse arrives for a kind already pending and not granted that cycle, set overflow[src] and drop the new event.
REQ-023 SHALL, when a pulse arrives for a kind granted in the same cycle, keep that kind pending; no overflow.
REQ-024 SHALL accept token_start and token_end high for one source in the same cycle; start treated as older.
REQ-025 SHALL clear overflow on clear_overflow; a simultaneous new overflow wins (bit stays set).
REQ-026 SHALL deassert event_valid when slot is consumed and nothing is pending.

Reset
REQ-027 SHALL on reset clear all pend_start, pend_end, older bits and overflow.
REQ-028 SHALL on reset drive event_valid=0, event_source=0, event_kind=0, round-robin pointer=0.
REQ-029 SHALL discard in-flight and pending events on reset mid-operation; pulses sampled during reset are ignored.

Structure
REQ-030 SHALL place event_kind_t enum (START=0, END=1) and event record type (source, kind) in package tt_um_jleugeri_event_pkg.
REQ-031 SHALL implement round-robin selection in sub-module tt_um_jleugeri_rr_arbiter (request vector + pointer in, one-hot grant and index out).
REQ-032 SHALL use no tristate, no latches, no second clock edge.

Verification
REQ-033 SHALL cover: token_start[2] pulse, ready=1 -> valid after 2 edges, source=2, kind=0, valid low next cycle.
REQ-034 SHALL cover: token_start[0..3] same cycle, ready=1 -> four events, sources 0,1,2,3 on consecutive cycles.
REQ-035 SHALL cover: ready=0 while start[1], then end[1] -> output held source=1 kind=0; on ready=1, start then end.
REQ-036 SHALL cover: end[3] captured, then start[3], ready=0 -> after ready=1, kind order 1 then 0.
REQ-037 SHALL cover: ready=0, start[0] twice 3 cycles apart -> overflow=4'b0001, one event emitted; clear_overflow -> 0.
REQ-038 SHALL cover: reset asserted with 3 events pending -> valid=0, overflow=0 next cycle, no stale event afterward.

Source files
------------

// File: rtl/tt_um_jleugeri_event_pkg.sv
// Shared types for the event arbiter: event kind and event record.
// Imported by the arbiter top and round-robin sub-module.
package tt_um_jleugeri_event_pkg;

  localparam int ID_W = 2;

  typedef enum logic {
    START = 1'b0,
    END   = 1'b1
  } event_kind_t;

  typedef struct packed {
    logic [ID_W-1:0] source;
    event_kind_t     kind;
  } event_t;

  // Older kind goes first when both are pending.
  function automatic event_kind_t pick_kind(
    input logic ps,
    input logic pe,
    input logic older
  );
    if (ps && pe) return event_kind_t'(older);
    return pe ? END : START;
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_rr_arbiter.sv
// Round-robin selector: first request at or after ptr_i wins.
// Ports: req_i, ptr_i in; one-hot grant_o, idx_o, valid_o out.
module tt_um_jleugeri_rr_arbiter
  import tt_um_jleugeri_event_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int p;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = |req_i;
    p       = 0;
    // Walk offsets high to low so the nearest request wins last.
    for (int off = N - 1; off >= 0; off--) begin
      p = int'(ptr_i) + off;
      if (p >= N) p = p - N;
      if (req_i[p]) begin
        grant_o    = '0;
        grant_o[p] = 1'b1;
        idx_o      = IW'(p);
      end
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_event_arbiter.sv
// Merges per-source start/end pulses into one valid/ready event stream.
// Ports: clock, reset, token_start/end in; event_* out, overflow flags.
module tt_um_jleugeri_event_arbiter
  import tt_um_jleugeri_event_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int ID_BITS     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] token_start,
  input  logic [NUM_SOURCES-1:0] token_end,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [ID_BITS-1:0]     event_source,
  output logic                   event_kind,
  output logic [NUM_SOURCES-1:0] overflow,
  input  logic                   clear_overflow
);

  localparam int N = NUM_SOURCES;

  logic [N-1:0]       ps_q, ps_d;
  logic [N-1:0]       pe_q, pe_d;
  logic [N-1:0]       old_q, old_d;
  logic [N-1:0]       ov_q, ov_d;
  logic [ID_BITS-1:0] ptr_q, ptr_d;
  logic               valid_q, valid_d;
  event_t             slot_q, slot_d;

  logic               load;
  logic [N-1:0]       req;
  logic [N-1:0]       grant;
  logic [ID_BITS-1:0] gidx;
  logic               gvalid;
  event_kind_t        gkind;
  logic [N-1:0]       gs, ge;
  logic [N-1:0]       ps_a, pe_a;
  logic [N-1:0]       s_cap, e_cap;
  logic [N-1:0]       ov_new;

  // Slot takes a new event when empty or being consumed.
  assign load = !valid_q || event_ready;
  assign req  = load ? (ps_q | pe_q) : '0;

  tt_um_jleugeri_rr_arbiter #(
    .N  (N),
    .IW (ID_BITS)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .valid_o (gvalid)
  );

  assign gkind = pick_kind(ps_q[gidx], pe_q[gidx], old_q[gidx]);

  assign gs     = grant & {N{gkind == START}};
  assign ge     = grant & {N{gkind == END}};
  assign ps_a   = ps_q & ~gs;
  assign pe_a   = pe_q & ~ge;
  // A pulse is dropped only if its kind stays pending this cycle.
  assign s_cap  = token_start & ~ps_a;
  assign e_cap  = token_end & ~pe_a;
  assign ov_new = (token_start & ps_a) | (token_end & pe_a);

  always_comb begin
    ps_d    = ps_a | token_start;
    pe_d    = pe_a | token_end;
    old_d   = old_q & ~grant;
    ov_d    = (clear_overflow ? '0 : ov_q) | ov_new;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    slot_d  = slot_q;
    for (int i = 0; i < N; i++) begin
      if (s_cap[i] && pe_a[i]) old_d[i] = 1'b1;
      else if (e_cap[i] && ps_a[i]) old_d[i] = 1'b0;
    end
    if (load) begin
      valid_d = gvalid;
      if (gvalid) begin
        slot_d.source = ID_W'(gidx);
        slot_d.kind   = gkind;
        ptr_d = (gidx == ID_BITS'(N - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q    <= '0;
      pe_q    <= '0;
      old_q   <= '0;
      ov_q    <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      slot_q  <= '{source: '0, kind: START};
    end else begin
      ps_q    <= ps_d;
      pe_q    <= pe_d;
      old_q   <= old_d;
      ov_q    <= ov_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign event_valid  = valid_q;
  assign event_source = ID_BITS'(slot_q.source);
  assign event_kind   = slot_q.kind;
  assign overflow     = ov_q;

endmodule

// File: tb/tb_tt_um_jleugeri_event_arbiter.sv
// Directed self-checking bench for the event arbiter.
// Drives pulses after each edge, checks 1 time unit after the edge.
module tb_tt_um_jleugeri_event_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] token_start;
  logic [3:0] token_end;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_source;
  logic       event_kind;
  logic [3:0] overflow;
  logic       clear_overflow;

  int checks = 0;
  int errors = 0;

  tt_um_jleugeri_event_arbiter #(
    .NUM_SOURCES (4),
    .ID_BITS     (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .token_start    (token_start),
    .token_end      (token_end),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_source   (event_source),
    .event_kind     (event_kind),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ev(input string tag,
                    input logic [1:0] src,
                    input logic kind);
    chk({tag, "_v"}, 32'(event_valid), 32'd1);
    chk({tag, "_s"}, 32'(event_source), 32'(src));
    chk({tag, "_k"}, 32'(event_kind), 32'(kind));
  endtask

  initial begin
    reset = 1'b1;
    token_start = '0;
    token_end = '0;
    event_ready = 1'b1;
    clear_overflow = 1'b0;
    tick();
    tick();
    chk("rst_v", 32'(event_valid), 32'd0);
    chk("rst_s", 32'(event_source), 32'd0);
    chk("rst_k", 32'(event_kind), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    reset = 1'b0;

    // single start on source 2: latency two edges
    token_start = 4'b0100;
    tick();
    token_start = '0;
    chk("lat_n", 32'(event_valid), 32'd0);
    tick();
    ev("lat", 2'd2, 1'b0);
    tick();
    chk("lat_off", 32'(event_valid), 32'd0);

    // reset pointer, then four simultaneous starts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    token_start = 4'b1111;
    tick();
    token_start = '0;
    tick();
    ev("rr0", 2'd0, 1'b0);
    tick();
    ev("rr1", 2'd1, 1'b0);
    tick();
    ev("rr2", 2'd2, 1'b0);
    tick();
    ev("rr3", 2'd3, 1'b0);
    tick();
    chk("rr_off", 32'(event_valid), 32'd0);

    // backpressure: start[1] then end[1]
    event_ready = 1'b0;
    token_start = 4'b0010;
    tick();
    token_start = '0;
    token_end = 4'b0010;
    tick();
    token_end = '0;
    ev("bp0", 2'd1, 1'b0);
    tick();
    tick();
    ev("bp_hold", 2'd1, 1'b0);
    event_ready = 1'b1;
    tick();
    ev("bp1", 2'd1, 1'b1);
    tick();
    chk("bp_off", 32'(event_valid), 32'd0);

    // start and end same cycle: start first
    token_start = 4'b0010;
    token_end = 4'b0010;
    tick();
    token_start = '0;
    token_end = '0;
    tick();
    ev("both0", 2'd1, 1'b0);
    tick();
    ev("both1", 2'd1, 1'b1);
    tick();
    chk("both_off", 32'(event_valid), 32'd0);

    // end[3] older than start[3] while slot busy
    event_ready = 1'b0;
    token_start = 4'b0001;
    tick();
    token_start = '0;
    token_end = 4'b1000;
    tick();
    token_end = '0;
    token_start = 4'b1000;
    tick();
    token_start = '0;
    ev("old0", 2'd0, 1'b0);
    event_ready = 1'b1;
    tick();
    ev("old1", 2'd3, 1'b1);
    tick();
    ev("old2", 2'd3, 1'b0);
    tick();
    chk("old_off", 32'(event_valid), 32'd0);

    // repeat pulse while same kind is being granted
    token_start = 4'b0001;
    tick();
    tick();
    token_start = '0;
    ev("rg0", 2'd0, 1'b0);
    tick();
    ev("rg1", 2'd0, 1'b0);
    tick();
    chk("rg_off", 32'(event_valid), 32'd0);
    chk("rg_ov", 32'(overflow), 32'd0);

    // overflow: start[0] twice 3 cycles apart, slot busy
    event_ready = 1'b0;
    token_end = 4'b0100;
    tick();
    token_end = '0;
    tick();
    token_start = 4'b0001;
    tick();
    token_start = '0;
    tick();
    tick();
    chk("ov_pre", 32'(overflow), 32'd0);
    token_start = 4'b0001;
    tick();
    token_start = '0;
    chk("ov_set", 32'(overflow), 32'b0001);
    ev("ov_e0", 2'd2, 1'b1);
    event_ready = 1'b1;
    tick();
    ev("ov_e1", 2'd0, 1'b0);
    tick();
    chk("ov_off", 32'(event_valid), 32'd0);
    chk("ov_keep", 32'(overflow), 32'b0001);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ov_clr", 32'(overflow), 32'd0);

    // new overflow beats simultaneous clear
    event_ready = 1'b0;
    token_start = 4'b0010;
    tick();
    token_start = '0;
    tick();
    token_start = 4'b0010;
    tick();
    clear_overflow = 1'b1;
    tick();
    token_start = '0;
    clear_overflow = 1'b0;
    chk("ovw_set", 32'(overflow), 32'b0010);
    ev("ovw_e0", 2'd1, 1'b0);
    event_ready = 1'b1;
    tick();
    ev("ovw_e1", 2'd1, 1'b0);
    tick();
    chk("ovw_off", 32'(event_valid), 32'd0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovw_clr", 32'(overflow), 32'd0);

    // reset with events pending and overflow set
    event_ready = 1'b0;
    token_start = 4'b0111;
    tick();
    token_start = '0;
    tick();
    token_start = 4'b0111;
    tick();
    token_start = '0;
    chk("mid_ov", 32'(overflow != 4'd0), 32'd1);
    reset = 1'b1;
    token_start = 4'b1111;
    token_end = 4'b1111;
    tick();
    chk("mid_v", 32'(event_valid), 32'd0);
    chk("mid_ovc", 32'(overflow), 32'd0);
    chk("mid_s", 32'(event_source), 32'd0);
    chk("mid_k", 32'(event_kind), 32'd0);
    reset = 1'b0;
    token_start = '0;
    token_end = '0;
    event_ready = 1'b1;
    tick();
    chk("post0", 32'(event_valid), 32'd0);
    tick();
    chk("post1", 32'(event_valid), 32'd0);
    tick();
    chk("post2", 32'(event_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
